// File: rtl/write_frame_ddr.sv
// Captures a 24-bit RGB pixel stream into a FIFO and writes each frame into one of
// two ping-pong DDR buffers with an Avalon-MM burst write master.
module write_frame_ddr #(
  parameter int H_PIXELS   = 1280,
  parameter int V_LINES    = 720,
  parameter int BURST_LEN  = 128,
  parameter int FIFO_DEPTH = 512
) (
  input  logic        clk_100,
  input  logic        reset_b,
  input  logic [7:0]  r_data,
  input  logic [7:0]  g_data,
  input  logic [7:0]  b_data,
  input  logic        valid_rgb,
  input  logic        sof,
  input  logic [29:0] addr_write_ddr1,
  input  logic [29:0] addr_write_ddr2,
  output logic        done_write_frame,
  output logic        wr_buf_sel,
  output logic [7:0]  count_write_frame,
  output logic        fifo_overflow,
  output logic        sof_err,
  output logic [29:0] avm_address,
  output logic [7:0]  avm_burstcount,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
);

  // state   | meaning
  // S_IDLE  | no frame in flight
  // S_FILL  | waiting until a whole burst sits in the FIFO
  // S_BURST | issuing one burst, one beat per accepted cycle
  // S_DONE  | frame accepted: pulse done, swap buffer, bump frame count
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_BURST, S_DONE} state_t;

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PW     = $clog2(H_PIXELS);
  localparam int LW     = $clog2(V_LINES);
  localparam int NBURST = H_PIXELS * V_LINES / BURST_LEN;
  localparam int NW     = $clog2(NBURST + 1);
  localparam int BW     = $clog2(BURST_LEN + 1);

  state_t          cs_q, ns;
  logic [23:0]     mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic            capturing_q, capturing_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]   line_cnt_q, line_cnt_d;
  logic            fifo_overflow_q, fifo_overflow_d;
  logic            sof_err_q, sof_err_d;
  logic [29:0]     frame_addr_q, frame_addr_d;
  logic [29:0]     avm_address_q, avm_address_d;
  logic [NW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            wr_buf_sel_q, wr_buf_sel_d;
  logic [7:0]      count_q, count_d;
  logic            take, full, accept, push, drop, last_pix;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign take     = valid_rgb & (capturing_q | sof);
  assign accept   = (cs_q == S_BURST) & ~avm_waitrequest;
  // A pop in the same cycle frees the slot the push lands in.
  assign push     = take & (~full | accept);
  assign drop     = take & full & ~accept;
  assign last_pix = (pix_cnt_q == PW'(H_PIXELS - 1)) && (line_cnt_q == LW'(V_LINES - 1));

  always_comb begin
    capturing_d     = capturing_q;
    pix_cnt_d       = pix_cnt_q;
    line_cnt_d      = line_cnt_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    fifo_overflow_d = fifo_overflow_q | drop;
    sof_err_d       = sof_err_q | (valid_rgb & sof & capturing_q);
    if (take) begin
      capturing_d = ~last_pix;
      if (last_pix) begin
        pix_cnt_d  = '0;
        line_cnt_d = '0;
      end else if (pix_cnt_q == PW'(H_PIXELS - 1)) begin
        pix_cnt_d  = '0;
        line_cnt_d = line_cnt_q + 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + 1'b1;
      end
    end
    if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (accept) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_comb begin
    ns            = cs_q;
    frame_addr_d  = frame_addr_q;
    avm_address_d = avm_address_q;
    burst_cnt_d   = burst_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    wr_buf_sel_d  = wr_buf_sel_q;
    count_d       = count_q;
    case (cs_q)
      S_IDLE: begin
        if (capturing_q) begin
          ns           = S_FILL;
          frame_addr_d = wr_buf_sel_q ? addr_write_ddr2 : addr_write_ddr1;
          burst_cnt_d  = '0;
        end
      end
      S_FILL: begin
        if (level >= (AW+1)'(BURST_LEN)) begin
          ns            = S_BURST;
          avm_address_d = frame_addr_q;
          beat_cnt_d    = '0;
        end
      end
      S_BURST: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BW'(BURST_LEN - 1)) begin
            if (burst_cnt_q == NW'(NBURST - 1)) begin
              ns = S_DONE;
            end else begin
              ns           = S_FILL;
              frame_addr_d = frame_addr_q + 30'(BURST_LEN);
              burst_cnt_d  = burst_cnt_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        wr_buf_sel_d = ~wr_buf_sel_q;
        count_d      = count_q + 8'd1;
        ns           = S_IDLE;
        // Next frame already streaming: go straight on with the other buffer.
        if (capturing_q) begin
          ns           = S_FILL;
          frame_addr_d = wr_buf_sel_q ? addr_write_ddr1 : addr_write_ddr2;
          burst_cnt_d  = '0;
        end
      end
      default: ns = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= {b_data, g_data, r_data};
  end

  always_ff @(posedge clk_100 or negedge reset_b) begin
    if (!reset_b) begin
      cs_q            <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      capturing_q     <= 1'b0;
      pix_cnt_q       <= '0;
      line_cnt_q      <= '0;
      fifo_overflow_q <= 1'b0;
      sof_err_q       <= 1'b0;
      frame_addr_q    <= '0;
      avm_address_q   <= '0;
      burst_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      wr_buf_sel_q    <= 1'b0;
      count_q         <= '0;
    end else begin
      cs_q            <= ns;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      capturing_q     <= capturing_d;
      pix_cnt_q       <= pix_cnt_d;
      line_cnt_q      <= line_cnt_d;
      fifo_overflow_q <= fifo_overflow_d;
      sof_err_q       <= sof_err_d;
      frame_addr_q    <= frame_addr_d;
      avm_address_q   <= avm_address_d;
      burst_cnt_q     <= burst_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      wr_buf_sel_q    <= wr_buf_sel_d;
      count_q         <= count_d;
    end
  end

  assign done_write_frame  = (cs_q == S_DONE);
  assign wr_buf_sel        = wr_buf_sel_q;
  assign count_write_frame = count_q;
  assign fifo_overflow     = fifo_overflow_q;
  assign sof_err           = sof_err_q;
  assign avm_write         = (cs_q == S_BURST);
  assign avm_address       = avm_address_q;
  assign avm_burstcount    = 8'(BURST_LEN);
  assign avm_writedata     = avm_write ? {8'h00, mem[rd_ptr_q[AW-1:0]]} : 32'h0;

endmodule

// File: tb/tb_write_frame_ddr.sv
// Directed bench for write_frame_ddr on a 256x4 frame with 16-beat bursts.
`timescale 1ns/1ps
module tb_write_frame_ddr;

  localparam int H     = 256;
  localparam int V     = 4;
  localparam int BL    = 16;
  localparam int FRAME = H * V;

  logic        clk_100 = 1'b0;
  logic        reset_b;
  logic [7:0]  r_data, g_data, b_data;
  logic        valid_rgb, sof;
  logic [29:0] addr1, addr2;
  logic        done_write_frame, wr_buf_sel, fifo_overflow, sof_err;
  logic [7:0]  count_write_frame, avm_burstcount;
  logic [29:0] avm_address;
  logic        avm_write, avm_waitrequest;
  logic [31:0] avm_writedata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_d;
  int          beat_idx = 0;
  int          total_beats = 0;
  int          done_cnt = 0;
  bit          exp_buf = 0;
  bit          chk_data = 1;
  bit          abort = 0;
  bit          stall_prev = 0;
  bit          last_prev = 0;
  logic [29:0] stall_addr;
  logic [31:0] stall_data;
  int          wr_mode = 0;
  int          wr_hold = 0;
  logic [23:0] pk = 24'hA50000;
  int          snap;

  write_frame_ddr #(.H_PIXELS(H), .V_LINES(V), .BURST_LEN(BL), .FIFO_DEPTH(512)) dut (
    .clk_100(clk_100), .reset_b(reset_b),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .valid_rgb(valid_rgb), .sof(sof),
    .addr_write_ddr1(addr1), .addr_write_ddr2(addr2),
    .done_write_frame(done_write_frame), .wr_buf_sel(wr_buf_sel),
    .count_write_frame(count_write_frame), .fifo_overflow(fifo_overflow), .sof_err(sof_err),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk_100 = ~clk_100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and scoreboard.
  initial begin
    forever begin
      @(negedge clk_100);
      if (stall_prev) begin
        chk("stall_write", 32'(avm_write), 32'd1);
        chk("stall_addr", 32'(avm_address), 32'(stall_addr));
        chk("stall_data", avm_writedata, stall_data);
      end
      stall_prev = avm_write && avm_waitrequest;
      stall_addr = avm_address;
      stall_data = avm_writedata;
      if (done_write_frame) begin
        chk("done_after_last", 32'(last_prev), 32'd1);
        chk("frame_beats", beat_idx, FRAME);
        beat_idx = 0;
        done_cnt++;
        exp_buf = !exp_buf;
      end
      last_prev = 0;
      if (avm_write && !avm_waitrequest) begin
        chk("burstcount", 32'(avm_burstcount), BL);
        chk("addr", 32'(avm_address), 32'((exp_buf ? addr2 : addr1) + 30'((beat_idx / BL) * BL)));
        if (chk_data) begin
          if (exp_q.size() == 0) chk("data_avail", 32'd0, 32'd1);
          else begin
            exp_d = exp_q.pop_front();
            chk("data", avm_writedata, exp_d);
          end
        end
        beat_idx++;
        total_beats++;
        last_prev = (beat_idx == FRAME);
      end
    end
  end

  // Waitrequest generator: 0 = off, 1 = ~30% random, 2 = stuck high; wr_hold forces a stall.
  initial begin
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk_100); #1;
      if (wr_hold > 0) begin
        avm_waitrequest = 1'b1;
        wr_hold--;
      end else if (wr_mode == 2) avm_waitrequest = 1'b1;
      else if (wr_mode == 1) avm_waitrequest = ($urandom_range(0, 99) < 30);
      else avm_waitrequest = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_pixels(input int n, input int sof_at, input bit track, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (abort) break;
      @(posedge clk_100); #1;
      valid_rgb = 1'b1;
      sof = (i == sof_at);
      {b_data, g_data, r_data} = pk;
      if (track) exp_q.push_back({8'h00, pk});
      pk++;
      if (gap) begin
        @(posedge clk_100); #1;
        valid_rgb = 1'b0;
        sof = 1'b0;
      end
    end
    @(posedge clk_100); #1;
    valid_rgb = 1'b0;
    sof = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cyc);
    int n = 0;
    while (done_cnt < target && n < max_cyc) begin
      @(posedge clk_100); #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_beats(input int target, input int max_cyc);
    int n = 0;
    while (beat_idx < target && n < max_cyc) begin
      @(posedge clk_100); #1;
      n++;
    end
    chk("beats_reached", 32'(beat_idx >= target), 32'd1);
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    valid_rgb = 1'b0;
    sof = 1'b0;
    wr_mode = 0;
    wr_hold = 0;
    repeat (3) @(posedge clk_100);
    #1;
    exp_q.delete();
    beat_idx = 0;
    exp_buf = 0;
    stall_prev = 0;
    last_prev = 0;
    done_cnt = 0;
    chk_data = 1;
    abort = 0;
    reset_b = 1'b1;
    @(posedge clk_100); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"}, 32'(done_write_frame), 32'd0);
    chk({tag, "_sel"}, 32'(wr_buf_sel), 32'd0);
    chk({tag, "_count"}, 32'(count_write_frame), 32'd0);
    chk({tag, "_ovf"}, 32'(fifo_overflow), 32'd0);
    chk({tag, "_soferr"}, 32'(sof_err), 32'd0);
    chk({tag, "_addr"}, 32'(avm_address), 32'd0);
    chk({tag, "_write"}, 32'(avm_write), 32'd0);
    chk({tag, "_wdata"}, avm_writedata, 32'd0);
    chk({tag, "_bcount"}, 32'(avm_burstcount), BL);
  endtask

  initial begin
    addr1 = 30'h1000;
    addr2 = 30'h8000;
    reset_b = 1'b0;
    valid_rgb = 1'b0;
    sof = 1'b0;
    {r_data, g_data, b_data} = '0;
    repeat (2) @(negedge clk_100);
    chk_idle_outputs("reset");
    do_reset();

    // One frame, no waitrequest: geometry, addresses, data.
    send_pixels(FRAME, 0, 1, 0);
    wait_done(1, 3000);
    chk("f1_sel", 32'(wr_buf_sel), 32'd1);
    chk("f1_count", 32'(count_write_frame), 32'd1);
    chk("f1_drained", exp_q.size(), 0);

    // Two back-to-back frames: buffers alternate 0x8000 then 0x1000.
    send_pixels(FRAME, 0, 1, 0);
    send_pixels(FRAME, 0, 1, 0);
    wait_done(3, 3000);
    chk("pp_count", 32'(count_write_frame), 32'd3);
    chk("pp_sel", 32'(wr_buf_sel), 32'd1);

    // Random waitrequest plus a 5-cycle hold mid-burst.
    wr_mode = 1;
    fork
      send_pixels(FRAME, 0, 1, 1);
      begin
        wait_beats(40, 3000);
        wr_hold = 5;
      end
    join
    wait_done(4, 3000);
    wr_mode = 0;
    chk("stall_count", 32'(count_write_frame), 32'd4);
    chk("stall_sel", 32'(wr_buf_sel), 32'd0);
    chk("stall_drained", exp_q.size(), 0);

    // Overflow with waitrequest stuck high.
    do_reset();
    wr_mode = 2;
    chk_data = 0;
    send_pixels(512, 0, 0, 0);
    chk("ovf_before", 32'(fifo_overflow), 32'd0);
    send_pixels(1, -1, 0, 0);
    chk("ovf_after", 32'(fifo_overflow), 32'd1);
    send_pixels(87, -1, 0, 0);
    wr_mode = 0;
    send_pixels(FRAME - 600, -1, 0, 1);
    send_pixels(FRAME, 0, 0, 1);
    wait_done(1, 3000);
    chk("ovf_count", 32'(count_write_frame), 32'd1);
    chk("ovf_soferr", 32'(sof_err), 32'd0);

    // sof at pixel 100 is flagged and otherwise ignored.
    do_reset();
    send_pixels(100, 0, 1, 0);
    chk("soferr_before", 32'(sof_err), 32'd0);
    send_pixels(FRAME - 100, 0, 1, 0);
    chk("soferr_after", 32'(sof_err), 32'd1);
    wait_done(1, 3000);
    chk("soferr_count", 32'(count_write_frame), 32'd1);
    chk("soferr_drained", exp_q.size(), 0);

    // Reset while beat 7 of the first burst is on the bus.
    do_reset();
    fork
      send_pixels(FRAME, 0, 1, 0);
      begin
        wait_beats(7, 500);
        chk("rst_busy", 32'(avm_write), 32'd1);
        reset_b = 1'b0;
        abort = 1;
        @(negedge clk_100);
        chk_idle_outputs("midrst");
      end
    join
    exp_q.delete();
    beat_idx = 0;
    exp_buf = 0;
    stall_prev = 0;
    last_prev = 0;
    done_cnt = 0;
    abort = 0;
    reset_b = 1'b1;
    snap = total_beats;
    send_pixels(200, -1, 0, 0);
    repeat (40) @(posedge clk_100);
    #1;
    chk("nosof_beats", total_beats, snap);
    chk("nosof_write", 32'(avm_write), 32'd0);
    send_pixels(FRAME, 0, 1, 0);
    wait_done(1, 3000);
    chk("rst_count", 32'(count_write_frame), 32'd1);
    chk("rst_sel", 32'(wr_buf_sel), 32'd1);
    chk("rst_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
